// File: rtl/flags_commit_ctrl_pkg.sv
// Shared definitions for the flags commit controller: status bit layout, AH packing
// and the LAHF service state type.
package flags_commit_ctrl_pkg;

    localparam int STATUS_W      = 7;
    localparam int STATUS_PF_BIT = 0;
    localparam int STATUS_AF_BIT = 1;
    localparam int STATUS_ZF_BIT = 2;
    localparam int STATUS_SF_BIT = 3;
    localparam int STATUS_CF_BIT = 4;
    localparam int STATUS_OF_BIT = 5;
    localparam int STATUS_IF_BIT = 6;

    localparam int FLAG_UPD_DF_BIT = 7;

    localparam int AH_CF_POS  = 0;
    localparam int AH_ONE_POS = 1;
    localparam int AH_PF_POS  = 2;
    localparam int AH_AF_POS  = 4;
    localparam int AH_ZF_POS  = 6;
    localparam int AH_SF_POS  = 7;

    typedef enum logic {
        IDLE      = 1'b0,
        LAHF_PEND = 1'b1
    } lahf_state_t;

    // AH = {SF, ZF, 0, AF, 0, PF, 1, CF}
    function automatic logic [7:0] pack_ah(input logic [STATUS_W-1:0] status);
        logic [7:0] ah;
        ah             = '0;
        ah[AH_CF_POS]  = status[STATUS_CF_BIT];
        ah[AH_ONE_POS] = 1'b1;
        ah[AH_PF_POS]  = status[STATUS_PF_BIT];
        ah[AH_AF_POS]  = status[STATUS_AF_BIT];
        ah[AH_ZF_POS]  = status[STATUS_ZF_BIT];
        ah[AH_SF_POS]  = status[STATUS_SF_BIT];
        return ah;
    endfunction

endpackage

// File: rtl/flags_commit_ctrl_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, search starting at ptr.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int IW   = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (enable && !found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/flags_commit_ctrl.sv
// Architectural status register with round-robin masked updates and LAHF service.
// Optional DF register is built when FLAGS_COMMIT_DF_EN is defined.
module flags_commit_ctrl
    import flags_commit_ctrl_pkg::*;
#(
    parameter int         N_REQ        = 3,
    parameter logic [6:0] STATUS_RESET = 7'h00,
    localparam int        IDX_W        = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_mask,
    input  logic [8*N_REQ-1:0]   req_value,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 lahf_req,
    output logic                 ah_valid,
    output logic [7:0]           ah_out,
    output logic [6:0]           status_out,
    output logic                 df_out,
    output logic                 commit_valid,
    output logic [IDX_W-1:0]     commit_src
);

    logic [7:0]       mask_arr  [N_REQ];
    logic [7:0]       value_arr [N_REQ];
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             handshake;
    logic [7:0]       sel_mask;
    logic [7:0]       sel_value;

    logic [6:0]       status_reg, status_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             commit_valid_reg;
    logic [IDX_W-1:0] commit_src_reg;
    logic             ah_valid_reg;
    logic [7:0]       ah_out_reg;
    lahf_state_t      state_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign mask_arr[gi]  = req_mask[8*gi +: 8];
            assign value_arr[gi] = req_value[8*gi +: 8];
        end
    endgenerate

    // Reset also gates the grant so no handshake is offered while in reset.
    rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_arb (
        .valid  (req_valid),
        .ptr    (rr_ptr_reg),
        .enable (!stall && !rst),
        .grant  (grant),
        .index  (grant_idx)
    );

    assign req_ready   = grant;
    assign handshake   = |grant;
    assign sel_mask    = mask_arr[grant_idx];
    assign sel_value   = value_arr[grant_idx];
    assign rr_ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Post-commit view, also used for the LAHF bypass.
    assign status_next = handshake
        ? ((status_reg & ~sel_mask[6:0]) | (sel_value[6:0] & sel_mask[6:0]))
        : status_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            status_reg       <= STATUS_RESET;
            rr_ptr_reg       <= '0;
            commit_valid_reg <= 1'b0;
            commit_src_reg   <= '0;
            ah_valid_reg     <= 1'b0;
            ah_out_reg       <= '0;
        end else begin
            commit_valid_reg <= handshake;
            ah_valid_reg     <= 1'b0;
            if (handshake) begin
                status_reg     <= status_next;
                rr_ptr_reg     <= rr_ptr_next;
                commit_src_reg <= grant_idx;
            end
            case (state_reg)
                IDLE: begin
                    if (lahf_req) begin
                        if (stall) begin
                            state_reg <= LAHF_PEND;
                        end else begin
                            ah_valid_reg <= 1'b1;
                            ah_out_reg   <= pack_ah(status_next);
                        end
                    end
                end
                LAHF_PEND: begin
                    if (!stall) begin
                        ah_valid_reg <= 1'b1;
                        ah_out_reg   <= pack_ah(status_next);
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FLAGS_COMMIT_DF_EN
    logic df_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            df_reg <= 1'b0;
        end else if (handshake && sel_mask[FLAG_UPD_DF_BIT]) begin
            df_reg <= sel_value[FLAG_UPD_DF_BIT];
        end
    end

    assign df_out = df_reg;
`else
    assign df_out = 1'b0;
`endif

    assign status_out   = status_reg;
    assign commit_valid = commit_valid_reg;
    assign commit_src   = commit_src_reg;
    assign ah_valid     = ah_valid_reg;
    assign ah_out       = ah_out_reg;

endmodule
